// File: rtl/threshold_stage.sv
// Binarises an even/odd RGB pair stream against a luma threshold, optionally adapting the
// threshold each frame to the previous frame's mean luma via a snapshot and serial divider.
module threshold_stage #(
    parameter int WIDTH     = 768,
    parameter int HEIGHT    = 512,
    parameter int THRESHOLD = 90,
    parameter int ADAPTIVE  = 0,
    parameter int INVERT    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       horizontal_Pulse_in,
    input  logic       vertical_Pulse_in,
    input  logic [7:0] data_Red_Even_in,
    input  logic [7:0] data_Green_Even_in,
    input  logic [7:0] data_Blue_Even_in,
    input  logic [7:0] data_Red_Odd_in,
    input  logic [7:0] data_Green_Odd_in,
    input  logic [7:0] data_Blue_Odd_in,
    output logic       horizontal_Pulse,
    output logic       vertical_Pulse,
    output logic [7:0] data_Red_Even,
    output logic [7:0] data_Green_Even,
    output logic [7:0] data_Blue_Even,
    output logic [7:0] data_Red_Odd,
    output logic [7:0] data_Green_Odd,
    output logic [7:0] data_Blue_Odd,
    output logic [7:0] threshold_level,
    output logic       sig_frame_done,
    output logic [1:0] fsm_state
);
    // Handshake: a pair is accepted on every rising edge where horizontal_Pulse_in is 1;
    // there is no back-pressure, and horizontal_Pulse marks valid output pairs 2 cycles later.

    localparam logic [31:0] DIVISOR   = 32'(WIDTH * HEIGHT);
    localparam logic [31:0] PAIR_LAST = 32'(WIDTH * HEIGHT / 2 - 1);
    localparam logic [7:0]  THR_INIT  = 8'(THRESHOLD);
    localparam bit          INV       = (INVERT != 0);
    localparam bit          ADAPT     = (ADAPTIVE != 0);

    typedef enum logic [1:0] {ACCUM = 2'd0, DIVIDE = 2'd1, UPDATE = 2'd2} state_t;

    state_t      state, state_next;
    logic [7:0]  y_even, y_odd;
    logic        valid_d1, vs_d1, last_d1, last_d2;
    logic [31:0] pair_cnt, acc, pair_sum;
    logic [32:0] rem, rem_sh, rem_sub;
    logic [31:0] quo;
    logic [4:0]  bit_cnt;
    logic        vs_rise, is_last, fits;
    logic [7:0]  pix_even, pix_odd;

    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
        logic [9:0] s;
        s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return s[9:2];
    endfunction

    assign vs_rise   = vertical_Pulse_in & ~vs_d1;
    assign is_last   = horizontal_Pulse_in && (pair_cnt == PAIR_LAST) && !vs_rise;
    assign pair_sum  = 32'(y_even) + 32'(y_odd);
    assign pix_even  = ((y_even > threshold_level) ^ INV) ? 8'hFF : 8'h00;
    assign pix_odd   = ((y_odd  > threshold_level) ^ INV) ? 8'hFF : 8'h00;
    assign fsm_state = state;

    // Stage e0: luma, valid, frame-end detection and pair counting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            y_even   <= '0;
            y_odd    <= '0;
            valid_d1 <= 1'b0;
            vs_d1    <= 1'b0;
            last_d1  <= 1'b0;
            pair_cnt <= '0;
        end else begin
            y_even   <= luma(data_Red_Even_in, data_Green_Even_in, data_Blue_Even_in);
            y_odd    <= luma(data_Red_Odd_in, data_Green_Odd_in, data_Blue_Odd_in);
            valid_d1 <= horizontal_Pulse_in;
            vs_d1    <= vertical_Pulse_in;
            last_d1  <= is_last;
            if (vs_rise)
                pair_cnt <= '0;
            else if (horizontal_Pulse_in)
                pair_cnt <= (pair_cnt == PAIR_LAST) ? '0 : pair_cnt + 32'd1;
        end
    end

    // Stage e1: threshold compare, output registers and accumulation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            horizontal_Pulse <= 1'b0;
            vertical_Pulse   <= 1'b0;
            data_Red_Even    <= '0;
            data_Green_Even  <= '0;
            data_Blue_Even   <= '0;
            data_Red_Odd     <= '0;
            data_Green_Odd   <= '0;
            data_Blue_Odd    <= '0;
            last_d2          <= 1'b0;
            acc              <= '0;
        end else begin
            horizontal_Pulse <= valid_d1;
            vertical_Pulse   <= vs_d1;
            data_Red_Even    <= valid_d1 ? pix_even : 8'h00;
            data_Green_Even  <= valid_d1 ? pix_even : 8'h00;
            data_Blue_Even   <= valid_d1 ? pix_even : 8'h00;
            data_Red_Odd     <= valid_d1 ? pix_odd  : 8'h00;
            data_Green_Odd   <= valid_d1 ? pix_odd  : 8'h00;
            data_Blue_Odd    <= valid_d1 ? pix_odd  : 8'h00;
            last_d2          <= last_d1;
            // On snapshot the pair currently in stage 1 starts the next frame's sum.
            if (vs_rise)
                acc <= '0;
            else if (last_d2)
                acc <= valid_d1 ? pair_sum : '0;
            else if (valid_d1)
                acc <= acc + pair_sum;
        end
    end

    always_comb begin
        rem_sh  = {rem[31:0], quo[31]};
        rem_sub = rem_sh - {1'b0, DIVISOR};
        fits    = (rem_sh >= {1'b0, DIVISOR});
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (last_d2) state_next = DIVIDE;
            DIVIDE:  if (last_d2) state_next = DIVIDE;
                     else if (bit_cnt == 5'd31) state_next = UPDATE;
            UPDATE:  state_next = last_d2 ? DIVIDE : ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ACCUM;
            rem             <= '0;
            quo             <= '0;
            bit_cnt         <= '0;
            sig_frame_done  <= 1'b0;
            threshold_level <= THR_INIT;
        end else begin
            state          <= state_next;
            sig_frame_done <= (state == UPDATE);
            if (state == UPDATE && ADAPT)
                threshold_level <= quo[7:0];
            if (last_d2) begin
                rem     <= '0;
                quo     <= acc;
                bit_cnt <= '0;
            end else if (state == DIVIDE) begin
                rem     <= fits ? rem_sub : rem_sh;
                quo     <= {quo[30:0], fits};
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_threshold_stage.sv
// Directed bench for threshold_stage: fixed, inverted and small adaptive-frame instances
// share one stimulus stream; expected values are hand-computed constants.
module tb_threshold_stage;
    logic       clk = 1'b0;
    logic       reset;
    logic       hs_in, vs_in;
    logic [7:0] re_in, ge_in, be_in, ro_in, go_in, bo_in;

    logic       a_hp, a_vp, a_fd;
    logic [7:0] a_re, a_ge, a_be, a_ro, a_go, a_bo, a_thr;
    logic [1:0] a_st;
    logic       i_hp, i_vp, i_fd;
    logic [7:0] i_re, i_ge, i_be, i_ro, i_go, i_bo, i_thr;
    logic [1:0] i_st;
    logic       s_hp, s_vp, s_fd;
    logic [7:0] s_re, s_ge, s_be, s_ro, s_go, s_bo, s_thr;
    logic [1:0] s_st;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    threshold_stage dut_a (
        .clk(clk), .reset(reset), .horizontal_Pulse_in(hs_in), .vertical_Pulse_in(vs_in),
        .data_Red_Even_in(re_in), .data_Green_Even_in(ge_in), .data_Blue_Even_in(be_in),
        .data_Red_Odd_in(ro_in), .data_Green_Odd_in(go_in), .data_Blue_Odd_in(bo_in),
        .horizontal_Pulse(a_hp), .vertical_Pulse(a_vp),
        .data_Red_Even(a_re), .data_Green_Even(a_ge), .data_Blue_Even(a_be),
        .data_Red_Odd(a_ro), .data_Green_Odd(a_go), .data_Blue_Odd(a_bo),
        .threshold_level(a_thr), .sig_frame_done(a_fd), .fsm_state(a_st)
    );

    threshold_stage #(.INVERT(1)) dut_i (
        .clk(clk), .reset(reset), .horizontal_Pulse_in(hs_in), .vertical_Pulse_in(vs_in),
        .data_Red_Even_in(re_in), .data_Green_Even_in(ge_in), .data_Blue_Even_in(be_in),
        .data_Red_Odd_in(ro_in), .data_Green_Odd_in(go_in), .data_Blue_Odd_in(bo_in),
        .horizontal_Pulse(i_hp), .vertical_Pulse(i_vp),
        .data_Red_Even(i_re), .data_Green_Even(i_ge), .data_Blue_Even(i_be),
        .data_Red_Odd(i_ro), .data_Green_Odd(i_go), .data_Blue_Odd(i_bo),
        .threshold_level(i_thr), .sig_frame_done(i_fd), .fsm_state(i_st)
    );

    threshold_stage #(.WIDTH(4), .HEIGHT(2), .ADAPTIVE(1)) dut_s (
        .clk(clk), .reset(reset), .horizontal_Pulse_in(hs_in), .vertical_Pulse_in(vs_in),
        .data_Red_Even_in(re_in), .data_Green_Even_in(ge_in), .data_Blue_Even_in(be_in),
        .data_Red_Odd_in(ro_in), .data_Green_Odd_in(go_in), .data_Blue_Odd_in(bo_in),
        .horizontal_Pulse(s_hp), .vertical_Pulse(s_vp),
        .data_Red_Even(s_re), .data_Green_Even(s_ge), .data_Blue_Even(s_be),
        .data_Red_Odd(s_ro), .data_Green_Odd(s_go), .data_Blue_Odd(s_bo),
        .threshold_level(s_thr), .sig_frame_done(s_fd), .fsm_state(s_st)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input logic [7:0] r_e, input logic [7:0] g_e, input logic [7:0] b_e,
                              input logic [7:0] r_o, input logic [7:0] g_o, input logic [7:0] b_o);
        hs_in = 1'b1;
        re_in = r_e; ge_in = g_e; be_in = b_e;
        ro_in = r_o; go_in = g_o; bo_in = b_o;
    endtask

    task automatic drive_gray(input logic [7:0] ye, input logic [7:0] yo);
        drive_pair(ye, ye, ye, yo, yo, yo);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hs_in = 1'b0;
        vs_in = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int pulses;
        logic [3:0] pat;
        reset = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        re_in = '0; ge_in = '0; be_in = '0; ro_in = '0; go_in = '0; bo_in = '0;
        tick();
        tick();
        check("rst_hp", a_hp, 0);
        check("rst_re", a_re, 0);
        check("rst_thr", a_thr, 90);
        check("rst_fd", s_fd, 0);
        check("rst_state", s_st, 0);
        reset = 1'b1;

        // Even Y=91 (above), odd Y=90 (equal, so not above).
        drive_gray(8'd91, 8'd90);
        tick();
        hs_in = 1'b0;
        tick();
        check("y91_even_r", a_re, 8'hFF);
        check("y91_even_b", a_be, 8'hFF);
        check("y90_odd_g", a_go, 8'h00);
        check("inv_y91_even", i_re, 8'h00);
        check("inv_y90_odd", i_ro, 8'hFF);
        tick();
        check("blank_hp", a_hp, 0);
        check("blank_re", a_re, 8'h00);
        check("blank_inv_ro", i_ro, 8'h00);

        // R=200,G=100,B=0 -> Y=100.
        drive_pair(8'd200, 8'd100, 8'd0, 8'd200, 8'd100, 8'd0);
        tick();
        hs_in = 1'b0;
        tick();
        check("y100_even", a_ge, 8'hFF);
        check("y100_odd", a_bo, 8'hFF);
        check("inv_y100_even", i_re, 8'h00);
        check("inv_y100_odd", i_go, 8'h00);

        pat = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            hs_in = (k < 4) ? pat[3 - k] : 1'b0;
            vs_in = (k < 4) ? pat[3 - k] : 1'b0;
            tick();
            if (k >= 1 && k <= 4) begin
                check("hs_delay", a_hp, (k - 1 < 4) ? pat[4 - k] : 1'b0);
                check("vs_delay", a_vp, (k - 1 < 4) ? pat[4 - k] : 1'b0);
            end
        end

        // Small adaptive frame: 4 pairs of Y=120 -> mean 120.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_gray(8'd120, 8'd120);
            tick();
        end
        hs_in = 1'b0;
        n = 0;
        while (!s_fd && n < 60) begin
            tick();
            n++;
        end
        check("fd_latency", n, 35);
        check("adapt_thr_120", s_thr, 120);
        check("fixed_thr", a_thr, 90);
        tick();
        check("fd_one_cycle", s_fd, 0);

        drive_gray(8'd120, 8'd121);
        tick();
        hs_in = 1'b0;
        tick();
        check("adapt_y120", s_re, 8'h00);
        check("adapt_y121", s_ro, 8'hFF);

        // Reset while the divider is running aborts the update.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_gray(8'd200, 8'd200);
            tick();
        end
        hs_in = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        check("mid_divide_state", s_st, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (s_fd) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        check("abort_thr", s_thr, 90);
        check("abort_re", s_re, 8'h00);
        check("abort_hp", s_hp, 0);

        // Two stale pairs, then a vsync rise restarts the frame.
        for (int k = 0; k < 2; k++) begin
            drive_gray(8'd50, 8'd50);
            tick();
        end
        hs_in = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            drive_gray(8'd200, 8'd200);
            tick();
        end
        hs_in = 1'b0;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (s_fd) pulses++;
        end
        check("vsync_pulses", pulses, 1);
        check("vsync_thr_200", s_thr, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
